spi_minion_shift: RTL and testbench

SPI_MINION_SHIFT -- requirements
Module: spi_minion_shift

---
 rtl/spi_minion_shift.sv | 135 +++++++++++++
 tb/tb_spi_minion_shift.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_minion_shift.sv
// SPI mode-0 minion front end: synchronises the pads into clk, shifts one nbits+2 frame
// per chip-select window, and trades words with an adapter through pull/push strobes.
module spi_minion_shift #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             pull_en,
    input  logic             pull_msg_val,
    input  logic             pull_msg_spc,
    input  logic [nbits-1:0] pull_msg_data,
    output logic             push_en,
    output logic             push_msg_val_wrt,
    output logic             push_msg_val_rd,
    output logic [nbits-1:0] push_msg_data
);
    localparam int FRAME_W = nbits + 2;
    localparam int CNT_W = $clog2(nbits + 3);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_FULL) ? CNT_FULL : v + CNT_W'(1);
    endfunction

    typedef enum logic {IDLE, SHIFT} state_t;

    logic       cs_p0, cs_p1, cs_p2;
    logic       sclk_p0, sclk_p1, sclk_p2;
    logic       mosi_p0, mosi_p1;
    logic [2:0] warm_p;

    // pad synchronisers (p0/p1) plus edge history (p2)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            warm_p  <= '0;
        end else begin
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
            warm_p  <= {warm_p[1:0], 1'b1};
        end
    end

    // Edges are trusted only once both history taps hold real pad samples, so a cs
    // already low when reset releases is not mistaken for a fresh frame start.
    logic armed, sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign armed     = warm_p[2];
    assign sclk_rise = armed &  sclk_p1 & ~sclk_p2;
    assign sclk_fall = armed & ~sclk_p1 &  sclk_p2;
    assign cs_fall   = armed & ~cs_p1 &  cs_p2;
    assign cs_rise   = armed &  cs_p1 & ~cs_p2;

    state_t             state;
    logic [FRAME_W-1:0] so_p0, so_nxt;
    logic [FRAME_W-1:0] si_p0;
    logic [CNT_W-1:0]   bit_cnt;
    logic               overrun;

    always_comb begin
        so_nxt = so_p0;
        if (pull_en)
            so_nxt = {pull_msg_val, pull_msg_spc, pull_msg_data};
        else if (state == SHIFT && sclk_fall)
            so_nxt = {so_p0[FRAME_W-2:0], 1'b0};
    end

    // frame FSM, shift registers and registered adapter strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            so_p0            <= '0;
            si_p0            <= '0;
            bit_cnt          <= '0;
            overrun          <= 1'b0;
            miso             <= 1'b0;
            pull_en          <= 1'b0;
            push_en          <= 1'b0;
            push_msg_val_wrt <= 1'b0;
            push_msg_val_rd  <= 1'b0;
            push_msg_data    <= '0;
        end else begin
            pull_en <= 1'b0;
            push_en <= 1'b0;
            so_p0   <= so_nxt;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state   <= SHIFT;
                        pull_en <= 1'b1;
                        bit_cnt <= '0;
                        overrun <= 1'b0;
                        si_p0   <= '0;
                    end
                end
                SHIFT: begin
                    miso <= so_nxt[FRAME_W-1];
                    if (cs_rise) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                        // only an exact-length frame reaches the adapter
                        if (bit_cnt == CNT_FULL && !overrun) begin
                            push_en          <= 1'b1;
                            push_msg_val_wrt <= si_p0[FRAME_W-1];
                            push_msg_val_rd  <= si_p0[FRAME_W-2];
                            push_msg_data    <= si_p0[nbits-1:0];
                        end
                    end else if (sclk_rise) begin
                        si_p0   <= {si_p0[FRAME_W-2:0], mosi_p1};
                        bit_cnt <= sat_cnt_inc(bit_cnt);
                        if (bit_cnt == CNT_FULL)
                            overrun <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_minion_shift.sv
// Bench for spi_minion_shift: an SPI master drives frames, a queue-based scoreboard checks
// pull/push strobes while the master checks miso bits against the response word.
module tb_spi_minion_shift;
    localparam int NB = 8;
    localparam int FW = NB + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic          pull_en;
    logic          pull_msg_val = 1'b0;
    logic          pull_msg_spc = 1'b0;
    logic [NB-1:0] pull_msg_data = '0;
    logic          push_en;
    logic          push_msg_val_wrt;
    logic          push_msg_val_rd;
    logic [NB-1:0] push_msg_data;

    spi_minion_shift #(.nbits(NB)) dut (
        .clk(clk),
        .reset(rst_n),
        .cs(cs),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .pull_en(pull_en),
        .pull_msg_val(pull_msg_val),
        .pull_msg_spc(pull_msg_spc),
        .pull_msg_data(pull_msg_data),
        .push_en(push_en),
        .push_msg_val_wrt(push_msg_val_wrt),
        .push_msg_val_rd(push_msg_val_rd),
        .push_msg_data(push_msg_data)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_push[$];
    int            exp_pull[$];
    logic [FW-1:0] last_push = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [FW-1:0] exp_frame;
        if (rst_n === 1'b1) begin
            if (pull_en === 1'b1) begin
                check("pull_with_push", 32'(push_en), 32'd0);
                check("pull_expected", 32'(exp_pull.size() > 0), 32'd1);
                if (exp_pull.size() > 0) exp_pull.delete(0);
            end
            if (push_en === 1'b1) begin
                check("push_expected", 32'(exp_push.size() > 0), 32'd1);
                if (exp_push.size() > 0) begin
                    exp_frame = exp_push.pop_front();
                    check("push_frame", 32'({push_msg_val_wrt, push_msg_val_rd, push_msg_data}),
                          32'(exp_frame));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_pull_en"}, 32'(pull_en), 32'd0);
        check({tag, "_push_en"}, 32'(push_en), 32'd0);
        check({tag, "_push_msg"}, 32'({push_msg_val_wrt, push_msg_val_rd, push_msg_data}), 32'd0);
    endtask

    task automatic check_idle();
        check("miso_idle", 32'(miso), 32'd0);
        check("push_msg_hold", 32'({push_msg_val_wrt, push_msg_val_rd, push_msg_data}),
              32'(last_push));
        check("pull_outstanding", 32'(exp_pull.size()), 32'd0);
        check("push_outstanding", 32'(exp_push.size()), 32'd0);
    endtask

    // one sclk pulse; k is the pulse index within the frame
    task automatic spi_bit(input logic b, input int k, input logic [FW-1:0] resp);
        logic exp_bit;
        mosi = b;
        wait_clk(5);
        exp_bit = (k < FW) ? resp[FW-1-k] : 1'b0;
        check("miso_bit", 32'(miso), 32'(exp_bit));
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
    endtask

    task automatic frame_start(input logic [FW-1:0] resp);
        pull_msg_val  = resp[FW-1];
        pull_msg_spc  = resp[FW-2];
        pull_msg_data = resp[NB-1:0];
        exp_pull.push_back(1);
        cs = 1'b0;
        wait_clk(1);
    endtask

    task automatic spi_frame(input int n, input logic [15:0] tx, input logic [FW-1:0] resp,
                             input int gap);
        frame_start(resp);
        for (int k = 0; k < n; k++) spi_bit(tx[n-1-k], k, resp);
        wait_clk(5);
        if (n == FW) begin
            exp_push.push_back(tx[FW-1:0]);
            last_push = tx[FW-1:0];
        end
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(gap);
        check_idle();
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] rsp;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(6);
        check_idle();

        // reference exchange: response {1,1,A5}, command {1,0,3C}
        spi_frame(FW, 16'({1'b1, 1'b0, 8'h3C}), {1'b1, 1'b1, 8'hA5}, 6);
        // short frame is dropped, previous push data retained
        spi_frame(7, 16'h005B, {1'b0, 1'b1, 8'h5A}, 6);
        // overlong frame dropped, then a legal one
        spi_frame(12, 16'h0ABC, {1'b1, 1'b0, 8'h0F}, 6);
        spi_frame(FW, 16'({1'b0, 1'b1, 8'hFF}), {1'b0, 1'b0, 8'h81}, 6);
        // cs toggles with no sclk: fresh pull only
        spi_frame(0, 16'h0000, {1'b1, 1'b0, 8'h33}, 6);

        // reset after five bits abandons the frame
        rsp = '1;
        frame_start(rsp);
        for (int k = 0; k < 5; k++) spi_bit(1'b1, k, rsp);
        wait_clk(2);
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        last_push = '0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(12);
        check_idle();
        cs = 1'b1;
        wait_clk(6);
        spi_frame(FW, 16'({1'b1, 1'b1, 8'h96}), {1'b0, 1'b1, 8'h3C}, 6);

        // back-to-back frames with the minimum cs-high gap
        spi_frame(FW, 16'({1'b1, 1'b0, 8'h12}), {1'b1, 1'b0, 8'hC3}, 4);
        spi_frame(FW, 16'({1'b0, 1'b1, 8'hED}), {1'b0, 1'b1, 8'h7E}, 4);

        for (int f = 0; f < 20; f++) begin
            int sel;
            int n;
            sel = int'($urandom_range(0, 5));
            n = (sel == 0) ? 7 : (sel == 1) ? 12 : (sel == 2) ? 3 : FW;
            spi_frame(n, 16'($urandom), FW'($urandom), int'($urandom_range(4, 8)));
        end

        wait_clk(20);
        check("final_pull_outstanding", 32'(exp_pull.size()), 32'd0);
        check("final_push_outstanding", 32'(exp_push.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
